// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the iterative shift unit:
//   - op_e    : operation encoding carried on the 3-bit Op port
//   - state_e : control FSM states (IDLE, SHIFT, DONE)
// Encodings not listed in op_e are treated as pass-through by the datapath.
// -----------------------------------------------------------------------------
package shift_pkg;

  typedef enum logic [2:0] {
    OP_SHL  = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHRA = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Purely combinational single-step shifter: moves i_value by i_amount bit
// positions according to i_op. The caller limits i_amount to 0..STEP.
//
// Configuration macro: SHIFT_UNIT_ROTATE_EN
//   defined   -> ROL/ROR implemented (bits wrap end-to-end)
//   undefined -> ROL/ROR encodings pass i_value through; no rotate logic built
//
// Ports
//   i_value  [WIDTH-1:0]  value to shift
//   i_op     [2:0]        operation (shift_pkg::op_e encoding)
//   i_amount [CNT_W-1:0]  shift distance, 0..WIDTH
//   o_result [WIDTH-1:0]  shifted value
// -----------------------------------------------------------------------------
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [2:0]       i_op,
  input  logic [CNT_W-1:0] i_amount,
  output logic [WIDTH-1:0] o_result
);

`ifdef SHIFT_UNIT_ROTATE_EN
  // Complementary distance for the wrapped-around part of a rotate. When
  // i_amount is 0 this equals WIDTH, and a shift by WIDTH yields zero, so the
  // OR below degenerates cleanly to i_value.
  logic [CNT_W-1:0] w_back;
  assign w_back = CNT_W'(WIDTH) - i_amount;
`endif

  always_comb begin
    // NOTE: default assignment first so no path leaves o_result unassigned,
    // which would otherwise infer a latch.
    o_result = i_value;
    case (i_op)
      OP_SHL:  o_result = i_value << i_amount;
      OP_SHR:  o_result = i_value >> i_amount;
      // Arithmetic shift replicates the current MSB; the work register keeps
      // the operand's sign bit in place across every step.
      OP_SHRA: o_result = $signed(i_value) >>> i_amount;
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROL:  o_result = (i_value << i_amount) | (i_value >> w_back);
      OP_ROR:  o_result = (i_value >> i_amount) | (i_value << w_back);
`endif
      default: o_result = i_value;
    endcase
  end

endmodule : shift_step

// File: rtl/shift_unit.sv
// -----------------------------------------------------------------------------
// shift_unit
// Multi-cycle shifter/rotator. An accepted request loads operand A into a
// work register and an effective shift count n into a down-counter; each
// cycle in SHIFT moves the work register by up to STEP positions. Result is
// loaded on the edge that enters DONE and held until the next completion.
//
// Parameters
//   WIDTH  datapath width, power of two, >= 8 (default 32)
//   STEP   maximum bit positions shifted per cycle, 1..WIDTH (default 1)
//
// Configuration macro: SHIFT_UNIT_ROTATE_EN
//   defined   -> Op 011 (ROL) / 100 (ROR) rotate by B mod WIDTH
//   undefined -> Op 011 / 100 behave as pass-through (n = 0, Result = A)
//
// Ports
//   clk     in   clock, all state changes on the rising edge
//   clr_n   in   asynchronous active-low reset
//   start   in   request, accepted in IDLE or DONE, ignored in SHIFT
//   Op      in   [2:0] operation: SHL, SHR, SHRA, ROL, ROR, else pass-through
//   A       in   [WIDTH-1:0] operand, captured on accept
//   B       in   [WIDTH-1:0] shift amount, captured on accept
//   busy    out  high while in SHIFT
//   done    out  one-cycle pulse in DONE; Result valid
//   Result  out  [WIDTH-1:0] registered result
//
// Timing: done is visible in the cycle after edge ceil(n/STEP), where the
// accept edge is edge 0. Back-to-back requests may be accepted in DONE.
// -----------------------------------------------------------------------------
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int LOG_W = $clog2(WIDTH);
  localparam int CNT_W = LOG_W + 1;

  localparam logic [CNT_W-1:0] STEP_C  = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_B = WIDTH'(WIDTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           r_state;
  logic [WIDTH-1:0] r_work;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic [CNT_W-1:0] w_n;
  logic [CNT_W-1:0] w_chunk;
  logic [WIDTH-1:0] w_step_out;

  // SHIFT is the only state that refuses new work.
  assign w_accept = start && (r_state != ST_SHIFT);

  // ---------------------------------------------------------------------------
  // Effective shift count for the request on the inputs. Linear shifts clamp
  // at WIDTH using the full B value (a large B must not alias to a small
  // count); rotates only care about B mod WIDTH.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_n = '0;
    case (Op)
      OP_SHL, OP_SHR, OP_SHRA: w_n = (B >= WIDTH_B) ? WIDTH_C : B[CNT_W-1:0];
`ifdef SHIFT_UNIT_ROTATE_EN
      OP_ROL, OP_ROR:          w_n = {1'b0, B[LOG_W-1:0]};
`endif
      default:                 w_n = '0;
    endcase
  end

  // Distance moved this cycle: a full STEP, or whatever is left.
  assign w_chunk = (r_remaining > STEP_C) ? STEP_C : r_remaining;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_value  (r_work),
    .i_op     (r_op),
    .i_amount (w_chunk),
    .o_result (w_step_out)
  );

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs. busy/done are set together with the
  // state they belong to, so they mirror SHIFT/DONE exactly.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state     <= ST_IDLE;
      r_work      <= '0;
      r_op        <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order.
      case (r_state)
        ST_SHIFT: begin
          r_work      <= w_step_out;
          r_remaining <= r_remaining - w_chunk;
          if (r_remaining == w_chunk) begin
            // Last step: capture the post-shift value straight from the
            // step logic, since r_work only updates on this same edge.
            r_state  <= ST_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_step_out;
          end
        end

        // IDLE and DONE both accept requests; any unreachable encoding
        // falls in here as well and recovers to IDLE.
        default: begin
          if (w_accept) begin
            r_work      <= A;
            r_op        <= Op;
            r_remaining <= w_n;
            if (w_n != '0) begin
              r_state <= ST_SHIFT;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
            end else begin
              // Zero-length request completes on the accept edge itself.
              r_state  <= ST_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= A;
            end
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign Result = r_result;

endmodule : shift_unit

// File: tb/tb_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_unit
// Two shift_unit instances (STEP=1 and STEP=4, WIDTH=32) driven from separate
// input sets. Directed table vectors, a reference model that rotates/shifts
// one bit at a time, randomized requests, and hand-written sequences for
// back-to-back acceptance and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_shift_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          s_start [2];
  logic [2:0]    s_op    [2];
  logic [W-1:0]  s_a     [2];
  logic [W-1:0]  s_b     [2];
  logic          w_busy  [2];
  logic          w_done  [2];
  logic [W-1:0]  w_res   [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_unit #(.WIDTH(W), .STEP(1)) u_dut1 (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (s_start[0]),
    .Op     (s_op[0]),
    .A      (s_a[0]),
    .B      (s_b[0]),
    .busy   (w_busy[0]),
    .done   (w_done[0]),
    .Result (w_res[0])
  );

  shift_unit #(.WIDTH(W), .STEP(4)) u_dut4 (
    .clk    (clk),
    .clr_n  (clr_n),
    .start  (s_start[1]),
    .Op     (s_op[1]),
    .A      (s_a[1]),
    .B      (s_b[1]),
    .busy   (w_busy[1]),
    .done   (w_done[1]),
    .Result (w_res[1])
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int step_of(input int which);
    return (which == 0) ? 1 : 4;
  endfunction

  function automatic int model_n(input logic [2:0] op, input logic [W-1:0] b);
    case (op)
      3'b000, 3'b001, 3'b010: return (b >= 32'd32) ? 32 : int'(b);
`ifdef SHIFT_UNIT_ROTATE_EN
      3'b011, 3'b100:         return int'(b % 32'd32);
`endif
      default:                return 0;
    endcase
  endfunction

  function automatic logic [W-1:0] model_res(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] r;
    int n;
    r = a;
    n = model_n(op, b);
    for (int i = 0; i < n; i++) begin
      case (op)
        3'b000:  r = {r[W-2:0], 1'b0};
        3'b001:  r = {1'b0, r[W-1:1]};
        3'b010:  r = {a[W-1], r[W-1:1]};
        3'b011:  r = {r[W-2:0], r[W-1]};
        3'b100:  r = {r[0], r[W-1:1]};
        default: r = r;
      endcase
    end
    return r;
  endfunction

  function automatic int model_lat(input int which, input logic [2:0] op,
                                   input logic [W-1:0] b);
    int n;
    n = model_n(op, b);
    return (n + step_of(which) - 1) / step_of(which);
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Call while sampled #1 after an edge. Counts further edges until done is
  // seen; busy must be high on every sample before that.
  task automatic wait_done(input int which, input string tag, output int edges);
    edges = 0;
    while (!w_done[which] && edges < 100) begin
      check($sformatf("%s busy-while-shifting e%0d", tag, edges),
            32'(w_busy[which]), 32'd1);
      @(posedge clk);
      #1;
      edges++;
    end
    if (!w_done[which]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s done-timeout: got no done after %0d edges, expected done",
               tag, edges);
    end
  endtask

  task automatic run_txn(input int which, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input int exp_lat,
                         input string tag);
    int edges;
    logic [W-1:0] held;
    @(negedge clk);
    s_op[which]    = op;
    s_a[which]     = a;
    s_b[which]     = b;
    s_start[which] = 1'b1;
    @(posedge clk);
    #1;
    s_start[which] = 1'b0;
    wait_done(which, tag, edges);
    check($sformatf("%s latency", tag), 32'(edges), 32'(exp_lat));
    check($sformatf("%s result", tag), w_res[which], exp_res);
    check($sformatf("%s busy-in-done", tag), 32'(w_busy[which]), 32'd0);
    held = exp_res;
    @(posedge clk);
    #1;
    check($sformatf("%s done-one-cycle", tag), 32'(w_done[which]), 32'd0);
    check($sformatf("%s result-held", tag), w_res[which], held);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           lat1;
    int           lat4;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    bit saw_done;
    logic [2:0] r_op;
    logic [W-1:0] r_a, r_b;

    vecs.push_back('{"shl1x5",      3'b000, 32'h0000_0001, 32'd5,          32'h0000_0020, 5,  2});
    vecs.push_back('{"shr_b0",      3'b001, 32'h1234_5678, 32'd0,          32'h1234_5678, 0,  0});
    vecs.push_back('{"shra_b40",    3'b010, 32'h8000_0000, 32'd40,         32'hFFFF_FFFF, 32, 8});
    vecs.push_back('{"shl_b31",     3'b000, 32'h0000_000F, 32'd31,         32'h8000_0000, 31, 8});
    vecs.push_back('{"shr_bmax",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0000, 32, 8});
    vecs.push_back('{"shra_pos4",   3'b010, 32'h7000_0000, 32'd4,          32'h0700_0000, 4,  1});
    vecs.push_back('{"shra_neg6",   3'b010, 32'hF000_0000, 32'd6,          32'hFFC0_0000, 6,  2});
    vecs.push_back('{"pass_111",    3'b111, 32'hDEAD_BEEF, 32'd3,          32'hDEAD_BEEF, 0,  0});
    vecs.push_back('{"pass_101",    3'b101, 32'hCAFE_F00D, 32'd100,        32'hCAFE_F00D, 0,  0});
    vecs.push_back('{"shl_b32",     3'b000, 32'hFFFF_FFFF, 32'd32,         32'h0000_0000, 32, 8});
    vecs.push_back('{"shr_b31",     3'b001, 32'h8000_0000, 32'd31,         32'h0000_0001, 31, 8});
    vecs.push_back('{"rol_b32",     3'b011, 32'h1234_5678, 32'd32,         32'h1234_5678, 0,  0});
`ifdef SHIFT_UNIT_ROTATE_EN
    vecs.push_back('{"ror_b36",     3'b100, 32'h0000_00F1, 32'd36,         32'h1000_000F, 4,  1});
    vecs.push_back('{"rol_b33",     3'b011, 32'h8000_0001, 32'd33,         32'h0000_0003, 1,  1});
`else
    vecs.push_back('{"ror_b36",     3'b100, 32'h0000_00F1, 32'd36,         32'h0000_00F1, 0,  0});
    vecs.push_back('{"rol_b33",     3'b011, 32'h8000_0001, 32'd33,         32'h8000_0001, 0,  0});
`endif

    // Reset state, checked between clock edges.
    clr_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_start[k] = 1'b0;
      s_op[k]    = '0;
      s_a[k]     = '0;
      s_b[k]     = '0;
    end
    #12;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset busy d%0d", k),   32'(w_busy[k]), 32'd0);
      check($sformatf("reset done d%0d", k),   32'(w_done[k]), 32'd0);
      check($sformatf("reset result d%0d", k), w_res[k],       32'd0);
    end
    @(negedge clk);
    clr_n = 1'b1;

    // Table vectors on both step sizes.
    foreach (vecs[i]) begin
      run_txn(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat1,
              {vecs[i].name, " s1"});
      run_txn(1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat4,
              {vecs[i].name, " s4"});
    end

    // start held high: ignored during SHIFT, accepted in DONE.
    @(negedge clk);
    s_op[0] = 3'b000; s_a[0] = 32'h0000_0001; s_b[0] = 32'd5; s_start[0] = 1'b1;
    @(posedge clk);
    #1;
    s_op[0] = 3'b001; s_a[0] = 32'h0000_FFFF; s_b[0] = 32'd2;
    wait_done(0, "b2b first", edges);
    check("b2b first latency", 32'(edges), 32'd5);
    check("b2b first result", w_res[0], 32'h0000_0020);
    @(posedge clk);
    #1;
    check("b2b accepted-in-done busy", 32'(w_busy[0]), 32'd1);
    check("b2b accepted-in-done done", 32'(w_done[0]), 32'd0);
    wait_done(0, "b2b second", edges);
    s_start[0] = 1'b0;
    check("b2b second latency", 32'(edges), 32'd2);
    check("b2b second result", w_res[0], 32'h0000_3FFF);
    @(posedge clk);
    #1;
    check("b2b idle after second", 32'(w_done[0]), 32'd0);

    // Reset asserted mid-operation around edge 3 of a 10-step SHL.
    @(negedge clk);
    s_op[0] = 3'b000; s_a[0] = 32'h0000_0001; s_b[0] = 32'd10; s_start[0] = 1'b1;
    @(posedge clk);
    #1;
    s_start[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("abort busy before reset", 32'(w_busy[0]), 32'd1);
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    check("abort async busy", 32'(w_busy[0]), 32'd0);
    check("abort async done", 32'(w_done[0]), 32'd0);
    check("abort async result", w_res[0], 32'd0);
    @(negedge clk);
    clr_n = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (w_done[0] || w_busy[0]) saw_done = 1'b1;
    end
    check("abort no done/busy after release", 32'(saw_done), 32'd0);
    check("abort result stays zero", w_res[0], 32'd0);
    run_txn(0, 3'b000, 32'h0000_0003, 32'd2, 32'h0000_000C, 2, "after abort");

    // Randomized requests against the reference model.
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 40; t++) begin
        r_op = 3'($urandom_range(0, 7));
        r_a  = $urandom;
        r_b  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
        run_txn(k, r_op, r_a, r_b, model_res(r_op, r_a, r_b),
                model_lat(k, r_op, r_b),
                $sformatf("rand d%0d t%0d op%0d b%0d", k, t, r_op, r_b));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_shift_unit
